// File: rtl/booth_mul_seq_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states and Booth step ops.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package booth_mul_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_ADD = 2'd1,
      OP_SUB = 2'd2
   } op_t;

   // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], Q_1}.
   function automatic op_t booth_op(input logic q0, input logic q_1);
      case ({q0, q_1})
         2'b01:   return OP_ADD;
         2'b10:   return OP_SUB;
         default: return OP_NOP;
      endcase
   endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// Request/result bundle of the Booth multiplier: operands + start in, busy/done/product out.
// Latency: n/a (wires only).
// Backpressure: none; start is simply ignored by the slave while busy is high.
interface booth_mul_seq_if #(
   parameter int WIDTH = 4
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     Min;
   logic [WIDTH-1:0]     Q;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   Dout;

   modport master (output start, signed_mode, Min, Q, input busy, done, Dout);
   modport slave  (input start, signed_mode, Min, Q, output busy, done, Dout);
endinterface

// File: rtl/booth_mul_seq_ctrl.sv
// Booth control FSM and iteration down-counter; issues load/op/shift/capture and busy/done.
// Latency: WIDTH (signed) or WIDTH+1 (unsigned) CALC cycles plus one DONE cycle per request.
// Backpressure: start is only looked at in IDLE; requests while busy are dropped.
module booth_mul_seq_ctrl
   import booth_mul_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic signed_mode,
   input  logic q0,
   input  logic q_1,
   output logic load,
   output op_t  op,
   output logic shift,
   output logic capture,
   output logic busy,
   output logic done
);
   localparam int CW = $clog2(WIDTH + 2);

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;

   // Next-state, counter update and per-cycle datapath controls.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      load    = 1'b0;
      op      = OP_NOP;
      shift   = 1'b0;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load    = 1'b1;
               // Unsigned operands need one extra step to consume the zero extension bit.
               count_d = signed_mode ? CW'(WIDTH) : CW'(WIDTH + 1);
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            op      = booth_op(q0, q_1);
            shift   = 1'b1;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            capture = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, counter and registered handshake outputs; reset aborts any operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         busy    <= (state_d != ST_IDLE);
         done    <= (state_q == ST_DONE);
      end
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned WIDTH x WIDTH -> 2*WIDTH product.
// Latency: done pulses WIDTH+1 (signed) / WIDTH+2 (unsigned) cycles after the start edge.
// Backpressure: start ignored while busy; Dout held from done until the next accepted start.
module booth_mul_seq
   import booth_mul_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   booth_mul_seq_if.slave bus
);
   // One guard bit so A-M cannot overflow when M is the most negative value.
   localparam int XW = WIDTH + 1;

   logic [XW-1:0]        m_q, a_q, q_q, a_nxt;
   logic                 q1_q;
   logic                 mode_q;
   logic [2*WIDTH-1:0]   dout_q;

   logic                 load, shift, capture, busy, done;
   op_t                  op;

   booth_mul_seq_ctrl #(.WIDTH(WIDTH)) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .start       (bus.start),
      .signed_mode (bus.signed_mode),
      .q0          (q_q[0]),
      .q_1         (q1_q),
      .load        (load),
      .op          (op),
      .shift       (shift),
      .capture     (capture),
      .busy        (busy),
      .done        (done)
   );

   // Add/sub unit, modulo 2^(WIDTH+1).
   always_comb begin
      a_nxt = a_q;
      case (op)
         OP_ADD:  a_nxt = a_q + m_q;
         OP_SUB:  a_nxt = a_q - m_q;
         default: a_nxt = a_q;
      endcase
   end

   // Operand load, then one add/sub plus arithmetic right shift of {A,Q,Q_1} per CALC cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_q    <= '0;
         a_q    <= '0;
         q_q    <= '0;
         q1_q   <= 1'b0;
         mode_q <= 1'b0;
      end else if (load) begin
         m_q    <= {bus.signed_mode & bus.Min[WIDTH-1], bus.Min};
         q_q    <= {bus.signed_mode & bus.Q[WIDTH-1], bus.Q};
         a_q    <= '0;
         q1_q   <= 1'b0;
         mode_q <= bus.signed_mode;
      end else if (shift) begin
         {a_q, q_q, q1_q} <= {a_nxt[XW-1], a_nxt, q_q};
      end
   end

   // Product capture: signed runs one step short, so their product sits one bit higher in {A,Q}.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q <= '0;
      end else if (capture) begin
         dout_q <= mode_q ? {a_q[WIDTH-1:0], q_q[WIDTH:1]}
                          : {a_q[WIDTH-2:0], q_q};
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.Dout = dout_q;

endmodule
